multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle rework of the RV32I core.
- Sequences a datapath with one shared instruction/data memory port, an instruction register, an old-PC register, an ALU-result register and a memory-data register.
- Issues a memory request with a ready handshake.
- Sits between that datapath and the memory, replacing the single-cycle combinational control unit.

---
 rtl/ctrl_pkg.sv | 76 +++++++
 rtl/multicycle_ctrl_if.sv | 11 +
 rtl/alu_decoder.sv | 36 +++
 rtl/multicycle_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// opcodes and the select/operation codes seen by the ALU, SignExtend and
// the datapath muxes.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXEC_R,
      S_EXEC_I,
      S_EXEC_U,
      S_ALUWB,
      S_BRANCH,
      S_JAL,
      S_TRAP
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_t;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_src_t;

   typedef enum logic [1:0] {
      A_PC     = 2'b00,
      A_OLD_PC = 2'b01,
      A_RS1    = 2'b10,
      A_ZERO   = 2'b11
   } src_a_t;

   typedef enum logic [1:0] {
      B_RS2  = 2'b00,
      B_IMM  = 2'b01,
      B_FOUR = 2'b10
   } src_b_t;

   typedef enum logic [1:0] {
      RES_ALUOUT  = 2'b00,
      RES_MEMDATA = 2'b01,
      RES_ALU     = 2'b10
   } result_src_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

   // funct3 values the ALU can execute for R/I arithmetic
   function automatic logic funct3_supported(input logic [2:0] f3);
      return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory port: request, store strobe, address
// select and the completion handshake from memory.
interface multicycle_ctrl_if;
   logic mem_req;
   logic mem_write;
   logic adr_src;
   logic mem_ready;

   modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
   modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/alu_decoder.sv
// ALU operation decode from the FSM's alu_op and the instruction's
// funct3/funct7b5.
module alu_decoder
   import ctrl_pkg::*;
(
   input  alu_op_t   alu_op,
   input  logic [2:0] funct3,
   input  logic      funct7b5,
   input  logic      is_rtype,
   output alu_ctrl_t alu_ctrl,
   output logic      illegal
);

   // illegal ignores alu_op so the FSM can screen funct3 while still in DECODE
   always_comb begin
      alu_ctrl = ALU_ADD;
      illegal  = !funct3_supported(funct3);
      case (alu_op)
         ALUOP_ADD: alu_ctrl = ALU_ADD;
         ALUOP_SUB: alu_ctrl = ALU_SUB;
         default: begin
            case (funct3)
               3'b000: begin
                  if (is_rtype && funct7b5) alu_ctrl = ALU_SUB;
                  else                      alu_ctrl = ALU_ADD;
               end
               3'b010:  alu_ctrl = ALU_SLT;
               3'b110:  alu_ctrl = ALU_OR;
               3'b111:  alu_ctrl = ALU_AND;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   FETCH      | read instruction at PC, PC <= PC+4 on completion
//   DECODE     | branch/jump target (old PC + imm) into ALU-result reg
//   MEMADR     | rs1 + imm for load/store address
//   MEMREAD    | data read at ALU-result address
//   MEMWB      | write loaded data to rd
//   MEMWRITE   | data write at ALU-result address
//   EXEC_R     | rs1 op rs2
//   EXEC_I     | rs1 op imm
//   EXEC_U     | 0 + imm (lui)
//   ALUWB      | write ALU-result reg to rd
//   BRANCH     | compare rs1/rs2, take target on BEQ/BNE condition
//   JAL        | PC <= target, compute old PC + 4 for rd
//   TRAP       | illegal instruction, halted until reset
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W  = 7,
   parameter int ALUCTRL_W = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   multicycle_ctrl_if.master    mem,
   input  logic [OPCODE_W-1:0]  op,
   input  logic [2:0]           funct3,
   input  logic                 funct7b5,
   input  logic                 eq,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 reg_write,
   output logic [1:0]           alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           result_src,
   output logic [ALUCTRL_W-1:0] alu_ctrl,
   output logic [2:0]           imm_src,
   output logic                 instr_done,
   output logic                 trap
);

   state_t    state, state_nxt;
   alu_op_t   alu_op;
   alu_ctrl_t alu_dec;
   logic      f3_illegal;
   logic      is_rtype;
   logic      mem_req_s, mem_write_s, adr_src_s;
   logic      ir_write_s, pc_write_s, reg_write_s, done_s, trap_s;

   assign is_rtype = (op == OP_R);

   alu_decoder u_alu_decoder (
      .alu_op   (alu_op),
      .funct3   (funct3),
      .funct7b5 (funct7b5),
      .is_rtype (is_rtype),
      .alu_ctrl (alu_dec),
      .illegal  (f3_illegal)
   );

   // state register; reset lands in FETCH immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_FETCH;
      else     state <= state_nxt;
   end

   // next state and control outputs
   always_comb begin
      state_nxt   = state;
      mem_req_s   = 1'b0;
      mem_write_s = 1'b0;
      adr_src_s   = 1'b0;
      ir_write_s  = 1'b0;
      pc_write_s  = 1'b0;
      reg_write_s = 1'b0;
      done_s      = 1'b0;
      trap_s      = 1'b0;
      alu_src_a   = A_PC;
      alu_src_b   = B_RS2;
      result_src  = RES_ALUOUT;
      alu_op      = ALUOP_ADD;
      imm_src     = IMM_I;
      case (state)
         S_FETCH: begin
            mem_req_s  = 1'b1;
            alu_src_b  = B_FOUR;
            result_src = RES_ALU;
            if (mem.mem_ready) begin
               ir_write_s = 1'b1;
               pc_write_s = 1'b1;
               state_nxt  = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_a = A_OLD_PC;
            alu_src_b = B_IMM;
            case (op)
               OP_STORE:  imm_src = IMM_S;
               OP_BRANCH: imm_src = IMM_B;
               OP_JAL:    imm_src = IMM_J;
               OP_LUI:    imm_src = IMM_U;
               default:   imm_src = IMM_I;
            endcase
            case (op)
               OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
               OP_R:      state_nxt = f3_illegal ? S_TRAP : S_EXEC_R;
               OP_I:      state_nxt = f3_illegal ? S_TRAP : S_EXEC_I;
               OP_BRANCH: state_nxt = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
               OP_JAL:    state_nxt = S_JAL;
               OP_LUI:    state_nxt = S_EXEC_U;
               default:   state_nxt = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = A_RS1;
            alu_src_b = B_IMM;
            imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
            state_nxt = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            mem_req_s = 1'b1;
            adr_src_s = 1'b1;
            if (mem.mem_ready) state_nxt = S_MEMWB;
         end
         S_MEMWB: begin
            result_src  = RES_MEMDATA;
            reg_write_s = 1'b1;
            done_s      = 1'b1;
            state_nxt   = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req_s   = 1'b1;
            mem_write_s = 1'b1;
            adr_src_s   = 1'b1;
            if (mem.mem_ready) begin
               done_s    = 1'b1;
               state_nxt = S_FETCH;
            end
         end
         S_EXEC_R: begin
            alu_src_a = A_RS1;
            alu_src_b = B_RS2;
            alu_op    = ALUOP_FUNCT;
            state_nxt = S_ALUWB;
         end
         S_EXEC_I: begin
            alu_src_a = A_RS1;
            alu_src_b = B_IMM;
            alu_op    = ALUOP_FUNCT;
            state_nxt = S_ALUWB;
         end
         S_EXEC_U: begin
            alu_src_a = A_ZERO;
            alu_src_b = B_IMM;
            imm_src   = IMM_U;
            state_nxt = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_s = 1'b1;
            done_s      = 1'b1;
            state_nxt   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = A_RS1;
            alu_src_b  = B_RS2;
            alu_op     = ALUOP_SUB;
            imm_src    = IMM_B;
            pc_write_s = eq ^ funct3[0];
            done_s     = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_JAL: begin
            alu_src_a  = A_OLD_PC;
            alu_src_b  = B_FOUR;
            imm_src    = IMM_J;
            pc_write_s = 1'b1;
            state_nxt  = S_ALUWB;
         end
         S_TRAP: begin
            trap_s = 1'b1;
         end
         default: state_nxt = S_TRAP;
      endcase
   end

   // enables are forced low by rst combinationally so an in-flight request
   // is withdrawn in the same cycle reset arrives
   assign mem.mem_req   = mem_req_s   & ~rst;
   assign mem.mem_write = mem_write_s & ~rst;
   assign mem.adr_src   = adr_src_s;
   assign ir_write      = ir_write_s  & ~rst;
   assign pc_write      = pc_write_s  & ~rst;
   assign reg_write     = reg_write_s & ~rst;
   assign instr_done    = done_s      & ~rst;
   assign trap          = trap_s      & ~rst;
   assign alu_ctrl      = alu_dec;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: random instruction stream with random memory
// stalls; per-instruction expectations from an instruction-class model are
// queued at issue and checked by an independent monitor at retirement.
module tb_multicycle_ctrl;

   localparam int N_RANDOM  = 300;
   localparam int CYC_LIMIT = 30000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       eq;
   logic       ir_write, pc_write, reg_write, instr_done, trap;
   logic [1:0] alu_src_a, alu_src_b, result_src;
   logic [2:0] alu_ctrl, imm_src;

   multicycle_ctrl_if mif ();

   multicycle_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .mem        (mif),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .eq         (eq),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .result_src (result_src),
      .alu_ctrl   (alu_ctrl),
      .imm_src    (imm_src),
      .instr_done (instr_done),
      .trap       (trap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic       eq;
      bit         abort;
   } instr_t;

   typedef struct {
      int         len;
      int         regw;
      int         pcw;
      int         nrd;
      int         nwr;
      bit         trap;
      logic [2:0] imm;
      logic [1:0] ex_a;
      logic [1:0] ex_b;
      logic [2:0] ex_alu;
      logic [1:0] wb_src;
   } exp_t;

   exp_t   exp_q[$];
   instr_t dir_q[$];
   int     total = 0;
   int     bad   = 0;

   logic [2:0] legal_f3 [4] = '{3'b000, 3'b010, 3'b110, 3'b111};
   logic [6:0] bad_ops  [4] = '{7'b0000000, 7'b1111111, 7'b0010111, 7'b1100111};

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
      end
   endtask

   function automatic instr_t mk(input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic e, input bit ab);
      instr_t i;
      i.op = o; i.f3 = f3; i.f7 = f7; i.eq = e; i.abort = ab;
      return i;
   endfunction

   // Expected per-instruction behaviour derived from the instruction class:
   // cycle count with a zero-wait memory, write-enable counts, memory
   // accesses, and the operand/operation chosen in the decode and execute steps.
   function automatic exp_t model(input instr_t i);
      exp_t e;
      bit   is_r;
      e = '{default: 0};
      e.pcw = 1;
      is_r = (i.op == 7'b0110011);
      case (i.op)
         7'b0110011, 7'b0010011: begin
            case (i.f3)
               3'b000:  e.ex_alu = (is_r && i.f7) ? 3'b001 : 3'b000;
               3'b010:  e.ex_alu = 3'b101;
               3'b110:  e.ex_alu = 3'b011;
               3'b111:  e.ex_alu = 3'b010;
               default: e.trap = 1;
            endcase
            e.len = 4; e.regw = 1; e.imm = 3'd0;
            e.ex_a = 2'b10; e.ex_b = is_r ? 2'b00 : 2'b01; e.wb_src = 2'b00;
         end
         7'b0000011: begin
            e.len = 5; e.regw = 1; e.nrd = 1; e.imm = 3'd0;
            e.ex_a = 2'b10; e.ex_b = 2'b01; e.wb_src = 2'b01;
         end
         7'b0100011: begin
            e.len = 4; e.nwr = 1; e.imm = 3'd1;
            e.ex_a = 2'b10; e.ex_b = 2'b01;
         end
         7'b1100011: begin
            if (i.f3 > 3'd1) e.trap = 1;
            e.len = 3; e.pcw = 1 + int'(i.eq ^ i.f3[0]); e.imm = 3'd2;
            e.ex_a = 2'b10; e.ex_b = 2'b00; e.ex_alu = 3'b001;
         end
         7'b1101111: begin
            e.len = 4; e.regw = 1; e.pcw = 2; e.imm = 3'd3;
            e.ex_a = 2'b01; e.ex_b = 2'b10; e.wb_src = 2'b00;
         end
         7'b0110111: begin
            e.len = 4; e.regw = 1; e.imm = 3'd4;
            e.ex_a = 2'b11; e.ex_b = 2'b01; e.wb_src = 2'b00;
         end
         default: e.trap = 1;
      endcase
      if (e.trap) begin
         e.len = 3; e.regw = 0; e.pcw = 1; e.nrd = 0; e.nwr = 0;
      end
      return e;
   endfunction

   function automatic instr_t rand_instr();
      instr_t     i;
      int         k;
      logic [2:0] f3;
      k  = int'($urandom_range(0, 19));
      f3 = 3'($urandom_range(0, 7));
      i  = mk(7'b0, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      if (k <= 3) begin
         i.op = 7'b0110011;
         if (k != 3) i.f3 = legal_f3[$urandom_range(0, 3)];
      end else if (k <= 7) begin
         i.op = 7'b0010011;
         if (k != 7) i.f3 = legal_f3[$urandom_range(0, 3)];
      end else if (k <= 9)  i.op = 7'b0000011;
      else if (k <= 11)     i.op = 7'b0100011;
      else if (k <= 14) begin
         i.op = 7'b1100011;
         if (k != 14) i.f3 = 3'($urandom_range(0, 1));
      end else if (k <= 16) i.op = 7'b1101111;
      else if (k <= 18)     i.op = 7'b0110111;
      else                  i.op = bad_ops[$urandom_range(0, 3)];
      return i;
   endfunction

   task automatic check_reset(input string tag);
      chk({tag, "_enables"}, int'({mif.mem_req, mif.mem_write, ir_write, pc_write,
                                    reg_write, instr_done, trap}), 0);
      chk({tag, "_selects"}, int'({mif.adr_src, alu_src_a, alu_src_b, result_src, alu_ctrl}),
          int'(10'b0_00_10_10_000));
   endtask

   // ---------------- monitor ----------------
   int         m_len = 0, m_regw = 0, m_pcw = 0, m_irw = 0, m_rd = 0, m_wr = 0;
   logic [1:0] m_a_d, m_b_d, m_a_x, m_b_x, m_wb;
   logic [2:0] m_imm, m_alu;
   bit         m_in_trap = 0;

   task automatic mon_clear();
      m_len = 0; m_regw = 0; m_pcw = 0; m_irw = 0; m_rd = 0; m_wr = 0;
      m_a_d = '0; m_b_d = '0; m_a_x = '0; m_b_x = '0; m_wb = '0; m_imm = '0; m_alu = '0;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst) begin
         mon_clear();
         m_in_trap = 0;
      end else if (!m_in_trap) begin
         m_regw += int'(reg_write);
         m_pcw  += int'(pc_write);
         m_irw  += int'(ir_write);
         if (mif.mem_req && mif.mem_ready && mif.adr_src) begin
            if (mif.mem_write) m_wr++;
            else               m_rd++;
         end
         if (reg_write) m_wb = result_src;
         if (!(mif.mem_req && !mif.mem_ready)) begin
            if (m_len == 1) begin m_a_d = alu_src_a; m_b_d = alu_src_b; m_imm = imm_src; end
            if (m_len == 2) begin m_a_x = alu_src_a; m_b_x = alu_src_b; m_alu = alu_ctrl; end
            m_len++;
         end
         if (instr_done || trap) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_retire", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("trap_flag", int'(trap), int'(e.trap));
               chk("cycles", m_len, e.len);
               chk("reg_write_cnt", m_regw, e.regw);
               chk("pc_write_cnt", m_pcw, e.pcw);
               chk("ir_write_cnt", m_irw, 1);
               chk("mem_reads", m_rd, e.nrd);
               chk("mem_writes", m_wr, e.nwr);
               if (!e.trap) begin
                  chk("decode_srcs", int'({m_a_d, m_b_d}), int'(4'b0101));
                  chk("decode_imm", int'(m_imm), int'(e.imm));
                  chk("exec_src_a", int'(m_a_x), int'(e.ex_a));
                  chk("exec_src_b", int'(m_b_x), int'(e.ex_b));
                  chk("exec_alu", int'(m_alu), int'(e.ex_alu));
                  if (e.regw != 0) chk("wb_result_src", int'(m_wb), int'(e.wb_src));
               end
            end
            if (trap) m_in_trap = 1;
            mon_clear();
         end
      end
   end

   // ---------------- driver ----------------
   task automatic do_trap_phase();
      for (int c = 0; c < 12; c++) begin
         @(negedge clk); #1;
         chk("trap_held", int'(trap), 1);
         chk("trap_quiet", int'({mif.mem_req, mif.mem_write, ir_write, pc_write,
                                 reg_write, instr_done}), 0);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_reset("trap_reset");
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      mif.mem_ready = 1'b0;
   endtask

   initial begin : driver
      instr_t i;
      int     cyc;
      int     issued;
      int     n_total;
      bit     load_pending;
      bit     abort_mode;

      op = '0; funct3 = '0; funct7b5 = 1'b0; eq = 1'b0;
      mif.mem_ready = 1'b0;
      cyc = 0; issued = 0; load_pending = 0; abort_mode = 0;

      dir_q.push_back(mk(7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0)); // addi
      dir_q.push_back(mk(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0)); // lw
      dir_q.push_back(mk(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0)); // beq taken
      dir_q.push_back(mk(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0)); // beq not taken
      dir_q.push_back(mk(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0)); // bne taken
      dir_q.push_back(mk(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0)); // sub
      dir_q.push_back(mk(7'b0110011, 3'b100, 1'b0, 1'b0, 1'b0)); // xor: unsupported
      dir_q.push_back(mk(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0)); // bad opcode
      dir_q.push_back(mk(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1)); // sw, reset mid-access
      dir_q.push_back(mk(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0)); // jal
      dir_q.push_back(mk(7'b0110111, 3'b101, 1'b1, 1'b0, 1'b0)); // lui
      dir_q.push_back(mk(7'b0110011, 3'b010, 1'b0, 1'b0, 1'b0)); // slt
      dir_q.push_back(mk(7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0)); // or
      dir_q.push_back(mk(7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0)); // and
      dir_q.push_back(mk(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0)); // addi, funct7b5 ignored
      dir_q.push_back(mk(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0)); // bne not taken
      n_total = dir_q.size() + N_RANDOM;

      repeat (2) @(posedge clk);
      #1;
      mif.mem_ready = 1'b1;
      #1;
      check_reset("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      mif.mem_ready = 1'b0;

      while (1) begin
         @(posedge clk); #1;
         if (load_pending) begin
            i = (dir_q.size() > 0) ? dir_q.pop_front() : rand_instr();
            op = i.op; funct3 = i.f3; funct7b5 = i.f7; eq = i.eq;
            exp_q.push_back(model(i));
            issued++;
            abort_mode   = i.abort;
            load_pending = 0;
         end
         mif.mem_ready = abort_mode ? 1'b0 : ($urandom_range(0, 3) != 0);
         @(negedge clk);
         load_pending = ir_write;
         #1;
         if (abort_mode && mif.mem_write) begin
            rst = 1'b1;
            #1;
            chk("abort_mem_req", int'(mif.mem_req), 0);
            chk("abort_mem_write", int'(mif.mem_write), 0);
            chk("abort_adr_src", int'(mif.adr_src), 0);
            exp_q.delete();
            abort_mode   = 0;
            load_pending = 0;
            @(negedge clk);
            @(posedge clk); #1;
            rst = 1'b0;
            mif.mem_ready = 1'b1;
            #1;
            chk("post_abort_fetch_req", int'(mif.mem_req), 1);
            chk("post_abort_adr_src", int'(mif.adr_src), 0);
            mif.mem_ready = 1'b0;
         end else if (trap) begin
            do_trap_phase();
            load_pending = 0;
         end
         if (issued >= n_total && exp_q.size() == 0) break;
         cyc++;
         if (cyc > CYC_LIMIT) begin
            chk("cycle_budget", cyc, CYC_LIMIT);
            break;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
